// File: rtl/pipe_pkg.sv
// Shared pipeline-control definitions: FSM encoding, PC mux selects, register zero.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pipe_pkg;

    // Hazard controller states.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TIMEOUT  = 2'd2
    } state_t;

    // PC source mux selects.
    localparam logic PC_SEL_SEQ = 1'b0;   // PC + 4
    localparam logic PC_SEL_BR  = 1'b1;   // branch target

    // Architectural zero register; never a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: increments on inc, holds at all-ones.
// Latency: count reflects inc one clock later.
// Backpressure: none; inc is sampled every cycle.
//
// Ports: clk, rst_n (async active-low), inc (count this cycle), count (W-bit value).
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, data-memory waits.
// Latency: control outputs are combinational (zero cycles); counters/state update next edge.
// Backpressure: a pending memory access freezes the whole pipeline; timeout freezes until reset.
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   id_rs, id_rt, id_uses_rt        source operands of the ID instruction
//   ex_mem_read, ex_rt              load in EX and its destination
//   ex_branch_taken                 branch in EX resolved taken
//   mem_req, mem_ready              data-memory handshake for the MEM stage
//   pc_sel, pc_we, ifid_we, ifid_flush, idex_bubble, exmem_we, memwb_bubble
//                                   pipeline mux selects and register enables
//   mem_timeout                     sticky timeout flag (cleared only by reset)
//   stall_count, flush_count        saturating performance counters
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_sel,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_we,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

    state_t            state;
    logic [WAIT_W-1:0] wait_cnt;

    logic lu_haz;
    logic mem_stall;
    logic stall_inc;
    logic flush_inc;

    // Load-use: the load in EX writes a register the ID instruction reads.
    assign lu_haz = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // A new request in RUN stalls in the same cycle it is seen, not one later.
    assign mem_stall = ((state == MEM_WAIT) || ((state == RUN) && mem_req)) && !mem_ready;

    // A branch squashes the ID instruction, so a coincident load-use is not a stall.
    assign stall_inc = (state != TIMEOUT) && (mem_stall || (lu_haz && !ex_branch_taken));
    assign flush_inc = (state != TIMEOUT) && !mem_stall && ex_branch_taken;

    always_comb begin
        pc_sel       = PC_SEL_SEQ;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_we     = 1'b1;
        memwb_bubble = 1'b0;
        mem_timeout  = 1'b0;
        if (state == TIMEOUT) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
            mem_timeout  = 1'b1;
        end else if (mem_stall) begin
            // Full freeze: branch / load-use in EX/ID stay put and resolve afterwards.
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            exmem_we     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            pc_sel      = PC_SEL_BR;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (lu_haz) begin
            // One bubble suffices: the load advances to MEM and the hazard clears.
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !mem_ready) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_ONE;
                    end
                end
                MEM_WAIT: begin
                    // mem_req is not re-sampled here: the MEM stage is frozen on its request.
                    if (mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt < WAIT_LIMIT) begin
                        wait_cnt <= wait_cnt + WAIT_ONE;
                    end else begin
                        state <= TIMEOUT;
                    end
                end
                TIMEOUT: begin
                    state <= TIMEOUT;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_inc),
        .count (flush_count)
    );

endmodule
